// File: rtl/operand_issue.sv
// Operand-fetch and issue stage: decodes a MIPS word, reads the register file,
// tracks in-flight destinations in a scoreboard and registers ALU operands.
module operand_issue (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_instr,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_rs_val,
  output logic [31:0] o_rt_val,
  output logic [2:0]  o_alu_op,
  output logic [4:0]  o_dest,
  output logic        o_dest_we,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_illegal
);

  logic [31:0] r_rf [32];
  logic [31:0] r_pending;
  logic        r_out_valid;
  logic [31:0] r_rs_val;
  logic [31:0] r_rt_val;
  logic [2:0]  r_alu_op;
  logic [4:0]  r_dest;
  logic        r_dest_we;
  logic        r_illegal;

  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_dest;
  logic        w_legal;
  logic        w_is_r;
  logic        w_sext;
  logic [2:0]  w_op;
  logic        w_dest_we;
  logic [31:0] w_imm_ext;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic [31:0] w_wb_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_pend_eff;
  logic        w_hazard;
  logic        w_ready;
  logic        w_issue;
  logic        w_unused_shamt;

  assign w_rs           = i_instr[25:21];
  assign w_rt           = i_instr[20:16];
  assign w_unused_shamt = ^i_instr[10:6];

  always_comb begin
    w_legal = 1'b0;
    w_is_r  = 1'b0;
    w_sext  = 1'b0;
    w_op    = '0;
    case (i_instr[31:26])
      6'b000000: begin
        w_is_r = 1'b1;
        case (i_instr[5:0])
          6'b100100: begin w_legal = 1'b1; w_op = 3'b000; end
          6'b100101: begin w_legal = 1'b1; w_op = 3'b001; end
          6'b100000: begin w_legal = 1'b1; w_op = 3'b010; end
          6'b100010: begin w_legal = 1'b1; w_op = 3'b011; end
          6'b101010: begin w_legal = 1'b1; w_op = 3'b100; end
          default:   w_legal = 1'b0;
        endcase
      end
      6'b001000: begin w_legal = 1'b1; w_op = 3'b010; w_sext = 1'b1; end
      6'b001010: begin w_legal = 1'b1; w_op = 3'b100; w_sext = 1'b1; end
      6'b001100: begin w_legal = 1'b1; w_op = 3'b000; end
      6'b001101: begin w_legal = 1'b1; w_op = 3'b001; end
      default:   w_legal = 1'b0;
    endcase
  end

  assign w_dest    = w_is_r ? i_instr[15:11] : w_rt;
  assign w_dest_we = (w_dest != 5'd0);
  assign w_imm_ext = w_sext ? {{16{i_instr[15]}}, i_instr[15:0]} : {16'd0, i_instr[15:0]};

  // Same-cycle write-back both bypasses the operand and retires the hazard.
  assign w_rs_data = (w_rs == 5'd0) ? '0 :
                     (i_wb_we && (i_wb_addr == w_rs)) ? i_wb_data : r_rf[w_rs];
  assign w_rt_data = (w_rt == 5'd0) ? '0 :
                     (i_wb_we && (i_wb_addr == w_rt)) ? i_wb_data : r_rf[w_rt];

  assign w_wb_mask  = i_wb_we ? (32'd1 << i_wb_addr) : '0;
  assign w_pend_eff = r_pending & ~w_wb_mask;
  assign w_hazard   = w_pend_eff[w_rs] | (w_is_r & w_pend_eff[w_rt]) | w_pend_eff[w_dest];
  assign w_ready    = !w_legal || ((!r_out_valid || i_out_ready) && !w_hazard);
  assign w_issue    = i_in_valid && w_legal && w_ready;
  assign w_set_mask = (w_issue && w_dest_we) ? (32'd1 << w_dest) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rf <= '{default: '0};
    end else if (i_wb_we && (i_wb_addr != 5'd0)) begin
      r_rf[i_wb_addr] <= i_wb_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_wb_mask) | w_set_mask) & ~32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_rs_val    <= '0;
      r_rt_val    <= '0;
      r_alu_op    <= '0;
      r_dest      <= '0;
      r_dest_we   <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= i_in_valid && !w_legal;
      if (w_issue) begin
        r_out_valid <= 1'b1;
        r_rs_val    <= w_rs_data;
        r_rt_val    <= w_is_r ? w_rt_data : w_imm_ext;
        r_alu_op    <= w_op;
        r_dest      <= w_dest;
        r_dest_we   <= w_dest_we;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready  = w_ready;
  assign o_out_valid = r_out_valid;
  assign o_rs_val    = r_rs_val;
  assign o_rt_val    = r_rt_val;
  assign o_alu_op    = r_alu_op;
  assign o_dest      = r_dest;
  assign o_dest_we   = r_dest_we;
  assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed scenarios plus randomized traffic, all
// checked against a behavioural model of registers, scoreboard and output slot.
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [2:0]  alu_op;
  logic [4:0]  dest;
  logic        dest_we;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        illegal;

  operand_issue u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_instr     (instr),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_rs_val    (rs_val),
    .o_rt_val    (rt_val),
    .o_alu_op    (alu_op),
    .o_dest      (dest),
    .o_dest_we   (dest_we),
    .i_wb_we     (wb_we),
    .i_wb_addr   (wb_addr),
    .i_wb_data   (wb_data),
    .o_illegal   (illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_ov, m_we, m_ill;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_dest;

  localparam logic [5:0] FUNCTS [5] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A};
  localparam logic [5:0] IOPS   [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = '0;
      m_pend[i] = 1'b0;
    end
    m_ov = 0; m_we = 0; m_ill = 0;
    m_a = '0; m_b = '0; m_op = '0; m_dest = '0;
  endfunction

  function automatic void decode(input logic [31:0] ins, output bit legal, output bit is_r,
                                 output logic [2:0] op, output logic [31:0] imm);
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [15:0] im;
    opc = ins[31:26];
    fn  = ins[5:0];
    im  = ins[15:0];
    legal = 1; is_r = 0; op = 3'd0; imm = '0;
    if (opc == 6'h00) begin
      is_r = 1;
      if      (fn == 6'h24) op = 3'd0;
      else if (fn == 6'h25) op = 3'd1;
      else if (fn == 6'h20) op = 3'd2;
      else if (fn == 6'h22) op = 3'd3;
      else if (fn == 6'h2A) op = 3'd4;
      else legal = 0;
    end else if (opc == 6'h08) begin op = 3'd2; imm = {{16{im[15]}}, im}; end
    else if (opc == 6'h0A) begin op = 3'd4; imm = {{16{im[15]}}, im}; end
    else if (opc == 6'h0C) begin op = 3'd0; imm = {16'd0, im}; end
    else if (opc == 6'h0D) begin op = 3'd1; imm = {16'd0, im}; end
    else legal = 0;
  endfunction

  function automatic bit busy(input logic [4:0] idx, input bit wbwe, input logic [4:0] wba);
    return (idx != 0) && m_pend[idx] && !(wbwe && (wba == idx));
  endfunction

  function automatic logic [31:0] rd(input logic [4:0] idx, input bit wbwe,
                                     input logic [4:0] wba, input logic [31:0] wbd);
    if (idx == 0) return '0;
    if (wbwe && (wba == idx)) return wbd;
    return m_rf[idx];
  endfunction

  task automatic check_outputs();
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("illegal", {31'd0, illegal}, {31'd0, m_ill});
    if (m_ov) begin
      check("rs_val", rs_val, m_a);
      check("rt_val", rt_val, m_b);
      check("alu_op", {29'd0, alu_op}, {29'd0, m_op});
      check("dest", {27'd0, dest}, {27'd0, m_dest});
      check("dest_we", {31'd0, dest_we}, {31'd0, m_we});
    end
  endtask

  // One clock cycle: drive, check in_ready mid-cycle, clock, check outputs.
  task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit wbwe,
                      input logic [4:0] wba, input logic [31:0] wbd, output bit rdy_seen);
    bit          legal, is_r, haz, exp_rdy, issue;
    logic [2:0]  op;
    logic [31:0] imm, a, b;
    logic [4:0]  rs, rt, dst;
    in_valid = v; instr = ins; out_ready = ordy;
    wb_we = wbwe; wb_addr = wba; wb_data = wbd;
    #1;
    decode(ins, legal, is_r, op, imm);
    rs  = ins[25:21];
    rt  = ins[20:16];
    dst = is_r ? ins[15:11] : rt;
    haz = busy(rs, wbwe, wba) || (is_r && busy(rt, wbwe, wba)) || busy(dst, wbwe, wba);
    exp_rdy = !legal || ((!m_ov || ordy) && !haz);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    rdy_seen = in_ready;
    issue = v && legal && exp_rdy;
    a = rd(rs, wbwe, wba, wbd);
    b = is_r ? rd(rt, wbwe, wba, wbd) : imm;
    @(posedge clk);
    #1;
    m_ill = v && !legal;
    if (issue) begin
      m_ov = 1; m_a = a; m_b = b; m_op = op; m_dest = dst; m_we = (dst != 0);
    end else if (m_ov && ordy) begin
      m_ov = 0;
    end
    if (wbwe) m_pend[wba] = 0;
    if (issue && dst != 0) m_pend[dst] = 1;
    if (wbwe && wba != 0) m_rf[wba] = wbd;
    check_outputs();
  endtask

  task automatic idle(input bit ordy, input bit wbwe, input logic [4:0] wba, input logic [31:0] wbd);
    bit r;
    step(0, '0, ordy, wbwe, wba, wbd, r);
  endtask

  task automatic reset_now();
    in_valid = 0; wb_we = 0;
    rst_n = 0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rs_val", rs_val, 32'd0);
    check("rst_rt_val", rt_val, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    check("rst_dest", {27'd0, dest}, 32'd0);
    check("rst_dest_we", {31'd0, dest_we}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    model_reset();
    #1 rst_n = 1;
  endtask

  initial begin
    bit          r;
    int          kind;
    logic [4:0]  rs, rt, rd5, wba;
    logic [31:0] ins;
    bit          wbwe;
    int          cand [$];

    model_reset();
    #11;
    reset_now();

    // R-type issue with preloaded operands
    idle(1, 1, 5'd1, 32'd5);
    idle(1, 1, 5'd2, 32'd3);
    step(1, 32'h00221822, 1, 0, 0, 0, r);
    check("sub_accept", {31'd0, r}, 32'd1);
    check("sub_valid", {31'd0, out_valid}, 32'd1);
    check("sub_rs", rs_val, 32'd5);
    check("sub_rt", rt_val, 32'd3);
    check("sub_op", {29'd0, alu_op}, 32'd3);
    check("sub_dest", {27'd0, dest}, 32'd3);
    check("sub_we", {31'd0, dest_we}, 32'd1);
    idle(1, 1, 5'd3, 32'd2);

    // Immediate extension; ORI clears r4 hazard via same-cycle write-back
    step(1, 32'h2004FFFF, 1, 0, 0, 0, r);
    check("addi_rt", rt_val, 32'hFFFFFFFF);
    check("addi_op", {29'd0, alu_op}, 32'd2);
    step(1, 32'h3404FFFF, 1, 1, 5'd4, 32'd9, r);
    check("ori_accept", {31'd0, r}, 32'd1);
    check("ori_rt", rt_val, 32'h0000FFFF);
    check("ori_op", {29'd0, alu_op}, 32'd1);
    idle(1, 1, 5'd4, 32'd7);

    // RAW stall and release with bypass
    step(1, 32'h00222820, 1, 0, 0, 0, r);
    step(1, 32'h00A13024, 1, 0, 0, 0, r);
    check("raw_stall", {31'd0, r}, 32'd0);
    step(1, 32'h00A13024, 1, 1, 5'd5, 32'h1234, r);
    check("raw_release", {31'd0, r}, 32'd1);
    check("raw_bypass", rs_val, 32'h1234);
    idle(1, 1, 5'd6, 32'd6);

    // Backpressure
    step(1, 32'h00223825, 1, 0, 0, 0, r);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h0022402A, 0, 0, 0, 0, r);
      check("bp_stall", {31'd0, r}, 32'd0);
      check("bp_rs", rs_val, 32'd5);
      check("bp_rt", rt_val, 32'd3);
      check("bp_dest", {27'd0, dest}, 32'd7);
    end
    step(1, 32'h0022402A, 1, 0, 0, 0, r);
    check("bp_release", {31'd0, r}, 32'd1);
    check("bp_new_dest", {27'd0, dest}, 32'd8);
    check("bp_new_op", {29'd0, alu_op}, 32'd4);
    idle(1, 1, 5'd7, 32'd1);
    idle(1, 1, 5'd8, 32'd1);

    // Illegal opcode and r0 destination
    step(1, 32'hFC000000, 0, 0, 0, 0, r);
    check("ill_ready", {31'd0, r}, 32'd1);
    check("ill_pulse", {31'd0, illegal}, 32'd1);
    check("ill_no_valid", {31'd0, out_valid}, 32'd0);
    idle(1, 0, 0, 0);
    check("ill_drop", {31'd0, illegal}, 32'd0);
    step(1, 32'h00220020, 1, 0, 0, 0, r);
    check("r0_we", {31'd0, dest_we}, 32'd0);
    step(1, 32'h00002020, 1, 0, 0, 0, r);
    check("r0_no_pend", {31'd0, r}, 32'd1);
    idle(1, 1, 5'd4, 32'd4);

    // Reset mid-stall
    step(1, 32'h00222820, 1, 0, 0, 0, r);
    idle(0, 0, 0, 0);
    reset_now();
    step(1, 32'h00A13024, 1, 0, 0, 0, r);
    check("post_rst_ready", {31'd0, r}, 32'd1);
    check("post_rst_rs", rs_val, 32'd0);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      if (it == 200) reset_now();
      kind = $urandom_range(0, 9);
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd5 = 5'($urandom_range(0, 7));
      ins = $urandom;
      if (kind < 5)      ins = {6'h00, rs, rt, rd5, 5'd0, FUNCTS[kind]};
      else if (kind < 9) ins = {IOPS[kind-5], rs, rt, ins[15:0]};
      else if (ins[0])   ins = {6'h3F, ins[25:0]};
      else               ins = {6'h00, rs, rt, rd5, 5'd0, 6'h21};
      cand.delete();
      for (int j = 1; j < 32; j++) if (m_pend[j]) cand.push_back(j);
      wbwe = ($urandom_range(0, 2) != 0);
      if (cand.size() > 0 && $urandom_range(0, 3) != 0)
        wba = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        wba = 5'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0, wbwe, wba, $urandom, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
